// File: rtl/btn_conditioner.sv
// Button synchronizer/debouncer with set-mode gating for the clock front-end.
// Optional up/down auto-repeat is built when BTN_AUTO_REPEAT_EN is defined.
module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYC      = 2000000,
  parameter int unsigned REPEAT_DELAY_CYC  = 50000000,
  parameter int unsigned REPEAT_PERIOD_CYC = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_set_mod,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic set_mod_level,
  output logic set_mod_pulse,
  output logic left_pulse,
  output logic right_pulse,
  output logic up_pulse,
  output logic down_pulse
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [NB-1:0] raw;
  logic [NB-1:0] s1_q, s2_q;
  logic [NB-1:0] stab_q, stab_d, stab1_q;
  logic [NB-1:0] rise, press;
  logic [NB-1:0] pls_q, pls_d;
  logic [CW-1:0] cnt_q [NB];
  logic [CW-1:0] cnt_d [NB];
  logic          lvl_q, lvl_d;
  logic [1:0]    rpt;

  // bit 0 set_mod, 1 left, 2 right, 3 up, 4 down
  assign raw = {btn_down, btn_up, btn_right, btn_left, btn_set_mod};

  always_comb begin
    stab_d = stab_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stab_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stab_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // gating uses the pre-toggle level
  assign rise  = stab_q & ~stab1_q;
  assign press = {rise[4:1] & {4{lvl_q}}, rise[0]};
  assign lvl_d = lvl_q ^ rise[0];
  assign pls_d = press | {rpt, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      stab_q  <= '0;
      stab1_q <= '0;
      pls_q   <= '0;
      lvl_q   <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      stab_q  <= stab_d;
      stab1_q <= stab_q;
      pls_q   <= pls_d;
      lvl_q   <= lvl_d;
      for (int i = 0; i < NB; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam int unsigned RMAX =
    (REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC) ?
    REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC;
  localparam int unsigned RW = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY_CYC - 1);
  localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD_CYC - 1);

  logic [1:0]    run_q, run_d;
  logic [1:0]    rep_q, rep_d;
  logic [RW-1:0] rc_q [2];
  logic [RW-1:0] rc_d [2];
  logic          both;

  // up and down held together suppress repeat on both
  assign both = stab_q[3] & stab_q[4];

  always_comb begin
    run_d = '0;
    rep_d = '0;
    rpt   = '0;
    for (int j = 0; j < 2; j++) begin
      rc_d[j] = '0;
      if (press[3+j]) begin
        run_d[j] = 1'b1;
      end else if (run_q[j] && stab_q[3+j] && lvl_q && !both) begin
        run_d[j] = 1'b1;
        rep_d[j] = rep_q[j];
        rc_d[j]  = rc_q[j] + 1'b1;
        if (rep_q[j] ? (rc_q[j] == PER_LAST)
                     : (rc_q[j] == DLY_LAST)) begin
          rpt[j]   = 1'b1;
          rep_d[j] = 1'b1;
          rc_d[j]  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      run_q <= '0;
      rep_q <= '0;
      for (int j = 0; j < 2; j++) begin
        rc_q[j] <= '0;
      end
    end else begin
      run_q <= run_d;
      rep_q <= rep_d;
      for (int j = 0; j < 2; j++) begin
        rc_q[j] <= rc_d[j];
      end
    end
  end
`else
  assign rpt = '0;
`endif

  assign set_mod_level = lvl_q;
  assign set_mod_pulse = pls_q[0];
  assign left_pulse    = pls_q[1];
  assign right_pulse   = pls_q[2];
  assign up_pulse      = pls_q[3];
  assign down_pulse    = pls_q[4];

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a timestamp-based reference model.
// Define BTN_AUTO_REPEAT_EN for both DUT and bench to check auto-repeat.
module tb_btn_conditioner;

  localparam int D    = 4;
  localparam int RDLY = 20;
  localparam int RPER = 8;
  localparam int MAXC = 8192;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = '0;
  logic       set_mod_level, set_mod_pulse;
  logic       left_pulse, right_pulse, up_pulse, down_pulse;

  btn_conditioner #(
    .DEBOUNCE_CYC(D),
    .REPEAT_DELAY_CYC(RDLY),
    .REPEAT_PERIOD_CYC(RPER)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_set_mod(btn[0]),
    .btn_left(btn[1]),
    .btn_right(btn[2]),
    .btn_up(btn[3]),
    .btn_down(btn[4]),
    .set_mod_level(set_mod_level),
    .set_mod_pulse(set_mod_pulse),
    .left_pulse(left_pulse),
    .right_pulse(right_pulse),
    .up_pulse(up_pulse),
    .down_pulse(down_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [4:0] v;
  } ev_t;

  ev_t        q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic [4:0] raw_h [MAXC];
  int         last_rst = 0;
  logic [4:0] m_stab = '0;
  int         m_agree [5];
  int         m_acc [5];
  logic       m_lvl = 1'b0;
  logic [4:0] m_alive = '0;
  int         m_start [5];
  bit         done = 0;

  // Model: stable accepts a change once the synced value has differed
  // from it for D edges since the last agreement or acceptance.
  initial begin
    for (int b = 0; b < 5; b++) begin
      m_agree[b] = 0;
      m_acc[b]   = -100;
      m_start[b] = 0;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (cyc < MAXC) raw_h[cyc] = btn;
      if (reset) begin
        last_rst = cyc;
        m_stab   = '0;
        m_lvl    = 1'b0;
        m_alive  = '0;
        for (int b = 0; b < 5; b++) begin
          m_agree[b] = cyc;
          m_acc[b]   = -100;
        end
      end else begin
        logic [4:0] v;
        logic       both;
        logic       sy;
        int         dl;
        v = '0;
        both = m_stab[3] && m_stab[4];
        for (int b = 0; b < 5; b++) begin
          if (m_acc[b] == cyc - 1 && (b == 0 || m_lvl)) v[b] = 1'b1;
        end
`ifdef BTN_AUTO_REPEAT_EN
        for (int b = 3; b < 5; b++) begin
          if (m_alive[b] && m_stab[b] && m_lvl && !both) begin
            dl = cyc - m_start[b];
            if (dl == RDLY || (dl > RDLY && (dl - RDLY) % RPER == 0))
              v[b] = 1'b1;
          end else begin
            m_alive[b] = 1'b0;
          end
          if (m_acc[b] == cyc - 1 && m_lvl) begin
            m_alive[b] = 1'b1;
            m_start[b] = cyc;
          end
        end
`endif
        if (m_acc[0] == cyc - 1) m_lvl = ~m_lvl;
        for (int b = 0; b < 5; b++) begin
          sy = (cyc - 2 > last_rst) ? raw_h[cyc-2][b] : 1'b0;
          if (sy == m_stab[b]) begin
            m_agree[b] = cyc;
          end else if (cyc - m_agree[b] == D) begin
            m_stab[b]  = sy;
            m_agree[b] = cyc;
            if (sy) m_acc[b] = cyc;
          end
        end
        if (v != 0) q.push_back('{cyc, v});
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT pulses.
  initial begin
    logic [4:0] dv;
    ev_t        e;
    forever begin
      @(negedge clk);
      if (!done) begin
        dv = {down_pulse, up_pulse, right_pulse, left_pulse, set_mod_pulse};
        n_cmp++;
        if (set_mod_level !== m_lvl) begin
          n_bad++;
          $display("FAIL level cyc=%0d got=%b exp=%b",
                   cyc, set_mod_level, m_lvl);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
          e = q.pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_pulse cyc=%0d got=none exp=%b",
                   e.cyc, e.v);
        end
        if (dv != 0) begin
          n_cmp++;
          if (q.size() == 0) begin
            n_bad++;
            $display("FAIL extra_pulse cyc=%0d got=%b exp=none", cyc, dv);
          end else begin
            e = q.pop_front();
            if (e.cyc != cyc || e.v != dv) begin
              n_bad++;
              $display("FAIL pulse cyc=%0d got=%b exp=%b@%0d",
                       cyc, dv, e.v, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic hold(input logic [4:0] v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [4:0] rv;
    @(negedge clk);
    do_reset(3);
    n_cmp++;
    if ({set_mod_level, set_mod_pulse, left_pulse, right_pulse,
         up_pulse, down_pulse} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {set_mod_level, set_mod_pulse, left_pulse, right_pulse,
                up_pulse, down_pulse});
    end
    hold(5'b00000, 5);
    hold(5'b00001, 12); hold(5'b00000, 12);
    hold(5'b00001, 12); hold(5'b00000, 12);
    hold(5'b00010, 12); hold(5'b00000, 12);
    hold(5'b00001, 12); hold(5'b00000, 12);
    hold(5'b00010, 12); hold(5'b00000, 12);
    for (int i = 0; i < 5; i++) begin
      hold(5'b01000, 3); hold(5'b00000, 3);
    end
    hold(5'b01000, 12); hold(5'b00000, 12);
    hold(5'b00110, 12); hold(5'b00000, 12);
    hold(5'b10000, 4);
    do_reset(2);
    hold(5'b10000, 12); hold(5'b00000, 12);
    hold(5'b00001, 12); hold(5'b00000, 12);
    hold(5'b10000, 12); hold(5'b00000, 12);
    hold(5'b01000, 70); hold(5'b00000, 30);
    hold(5'b11000, 70); hold(5'b00000, 30);
    hold(5'b01000, 40); hold(5'b01001, 12);
    hold(5'b01000, 20); hold(5'b00000, 20);
    for (int i = 0; i < 60; i++) begin
      rv = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) != 0) rv[0] = 1'b0;
      if ($urandom_range(0, 24) == 0) do_reset($urandom_range(1, 3));
      hold(rv, $urandom_range(1, 40));
    end
    hold(5'b00000, 30);
    done = 1;
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse cyc=%0d got=none exp=%b", e.cyc, e.v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
